// File: rtl/pktbuf_rd_arbiter.sv
// Two-requester arbiter for the packet-buffer read port: round-robin grant, per-requester
// credits, and a tag pipeline matched to the memory read latency that steers returned lines.
module pktbuf_rd_arbiter #(
    parameter int AWIDTH  = 12,
    parameter int DWIDTH  = 520,
    parameter int RD_LAT  = 12,
    parameter int CREDITS = 16,
    parameter int CWIDTH  = $clog2(CREDITS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [AWIDTH-1:0] req0_addr,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DWIDTH-1:0] rsp0_data,
    input  logic              crd0_return,
    input  logic              req1_valid,
    input  logic [AWIDTH-1:0] req1_addr,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DWIDTH-1:0] rsp1_data,
    input  logic              crd1_return,
    output logic              mem_rden,
    output logic [AWIDTH-1:0] mem_rdaddress,
    input  logic              mem_rd_valid,
    input  logic [DWIDTH-1:0] mem_rddata,
    output logic [CWIDTH-1:0] credits0,
    output logic [CWIDTH-1:0] credits1,
    output logic [2:0]        err_flags
);

    localparam int                DRW        = $clog2(RD_LAT + 1);
    localparam logic [CWIDTH-1:0] CRED_MAX   = CWIDTH'(CREDITS);
    localparam logic [DRW-1:0]    DRAIN_INIT = DRW'(RD_LAT);

    logic              elig0, elig1;
    logic              grant0, grant1;
    logic              acc0, acc1;
    logic              head_vld, head_id;
    logic              ovf0, ovf1;

    logic              last_grant_q, last_grant_d;
    logic              mem_rden_q, mem_rden_d;
    logic [AWIDTH-1:0] mem_rdaddress_q, mem_rdaddress_d;
    logic              issue_id_q, issue_id_d;
    logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [RD_LAT-1:0] tag_id_q, tag_id_d;
    logic              rsp0_valid_q, rsp0_valid_d;
    logic              rsp1_valid_q, rsp1_valid_d;
    logic [DWIDTH-1:0] rsp0_data_q, rsp0_data_d;
    logic [DWIDTH-1:0] rsp1_data_q, rsp1_data_d;
    logic [CWIDTH-1:0] credits0_q, credits0_d;
    logic [CWIDTH-1:0] credits1_q, credits1_d;
    logic [2:0]        err_q, err_d;
    logic [DRW-1:0]    drain_q, drain_d;

    // Returns {overflow, next count}; a simultaneous take and give cancel out.
    function automatic logic [CWIDTH:0] credit_next(input logic [CWIDTH-1:0] cur,
                                                    input logic take,
                                                    input logic give);
        logic [CWIDTH:0] res;
        res = {1'b0, cur};
        if (take && !give) begin
            res = {1'b0, cur - CWIDTH'(1)};
        end else if (give && !take) begin
            if (cur == CRED_MAX) begin
                res = {1'b1, cur};
            end else begin
                res = {1'b0, cur + CWIDTH'(1)};
            end
        end
        return res;
    endfunction

    always_comb begin
        elig0  = req0_valid && (credits0_q != '0) && !rst;
        elig1  = req1_valid && (credits1_q != '0) && !rst;
        grant0 = elig0 && (!elig1 || last_grant_q);
        grant1 = elig1 && (!elig0 || !last_grant_q);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign acc0       = req0_valid && req0_ready;
    assign acc1       = req1_valid && req1_ready;
    assign head_vld   = tag_vld_q[RD_LAT-1];
    assign head_id    = tag_id_q[RD_LAT-1];

    always_comb begin
        last_grant_d    = last_grant_q;
        mem_rden_d      = acc0 || acc1;
        mem_rdaddress_d = mem_rdaddress_q;
        issue_id_d      = issue_id_q;
        tag_vld_d       = tag_vld_q;
        tag_id_d        = tag_id_q;
        rsp0_valid_d    = 1'b0;
        rsp1_valid_d    = 1'b0;
        rsp0_data_d     = rsp0_data_q;
        rsp1_data_d     = rsp1_data_q;
        err_d           = err_q;
        drain_d         = drain_q;
        credits0_d      = credits0_q;
        credits1_d      = credits1_q;
        ovf0            = 1'b0;
        ovf1            = 1'b0;

        if (acc0 || acc1) begin
            mem_rdaddress_d = acc1 ? req1_addr : req0_addr;
            issue_id_d      = acc1;
            last_grant_d    = acc1;
        end

        // Stage 0 captures the read currently on the memory port.
        tag_vld_d[0] = mem_rden_q;
        tag_id_d[0]  = issue_id_q;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end

        if (head_vld && mem_rd_valid) begin
            if (head_id) begin
                rsp1_valid_d = 1'b1;
                rsp1_data_d  = mem_rddata;
            end else begin
                rsp0_valid_d = 1'b1;
                rsp0_data_d  = mem_rddata;
            end
        end

        // Memory is not reset with us, so stale returns are tolerated until the drain expires.
        if (drain_q != '0) begin
            drain_d = drain_q - DRW'(1);
        end else begin
            if (mem_rd_valid && !head_vld) err_d[0] = 1'b1;
            if (head_vld && !mem_rd_valid) err_d[1] = 1'b1;
        end

        {ovf0, credits0_d} = credit_next(credits0_q, acc0, crd0_return);
        {ovf1, credits1_d} = credit_next(credits1_q, acc1, crd1_return);
        if (ovf0 || ovf1) err_d[2] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q    <= 1'b1;
            mem_rden_q      <= 1'b0;
            mem_rdaddress_q <= '0;
            issue_id_q      <= 1'b0;
            tag_vld_q       <= '0;
            rsp0_valid_q    <= 1'b0;
            rsp1_valid_q    <= 1'b0;
            rsp0_data_q     <= '0;
            rsp1_data_q     <= '0;
            credits0_q      <= CRED_MAX;
            credits1_q      <= CRED_MAX;
            err_q           <= '0;
            drain_q         <= DRAIN_INIT;
        end else begin
            last_grant_q    <= last_grant_d;
            mem_rden_q      <= mem_rden_d;
            mem_rdaddress_q <= mem_rdaddress_d;
            issue_id_q      <= issue_id_d;
            tag_vld_q       <= tag_vld_d;
            rsp0_valid_q    <= rsp0_valid_d;
            rsp1_valid_q    <= rsp1_valid_d;
            rsp0_data_q     <= rsp0_data_d;
            rsp1_data_q     <= rsp1_data_d;
            credits0_q      <= credits0_d;
            credits1_q      <= credits1_d;
            err_q           <= err_d;
            drain_q         <= drain_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_id_q <= tag_id_d;
    end

    assign mem_rden      = mem_rden_q;
    assign mem_rdaddress = mem_rdaddress_q;
    assign rsp0_valid    = rsp0_valid_q;
    assign rsp1_valid    = rsp1_valid_q;
    assign rsp0_data     = rsp0_data_q;
    assign rsp1_data     = rsp1_data_q;
    assign credits0      = credits0_q;
    assign credits1      = credits1_q;
    assign err_flags     = err_q;

endmodule

// File: tb/tb_pktbuf_rd_arbiter.sv
// Bench for pktbuf_rd_arbiter: behavioural memory, scoreboard of issued reads, credit model,
// a grant vector table and directed sequences for credits, errors and reset.
module tb_pktbuf_rd_arbiter;

    localparam int AW = 12;
    localparam int DW = 520;
    localparam int RL = 12;
    localparam int CR = 16;
    localparam int CW = $clog2(CR + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [AW-1:0] req0_addr, req1_addr;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_data, rsp1_data;
    logic          crd0_return, crd1_return;
    logic          mem_rden, mem_rd_valid;
    logic [AW-1:0] mem_rdaddress;
    logic [DW-1:0] mem_rddata;
    logic [CW-1:0] credits0, credits1;
    logic [2:0]    err_flags;
    logic          suppress = 1'b0;
    logic          inject   = 1'b0;
    bit            mon_en   = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int owed0 = 0;
    int owed1 = 0;
    int exp_c0 = CR;
    int exp_c1 = CR;
    bit prev_acc = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    typedef struct { bit id; logic [AW-1:0] addr; int cyc; } sb_t;
    sb_t sb[$];

    typedef struct { bit v0; bit v1; logic [AW-1:0] a0; logic [AW-1:0] a1; bit r0; bit r1; } vec_t;
    vec_t tbl[8];

    bit            mp_v [RL];
    logic [AW-1:0] mp_a [RL];

    pktbuf_rd_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .RD_LAT(RL), .CREDITS(CR), .CWIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .crd0_return(crd0_return),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .crd1_return(crd1_return),
        .mem_rden(mem_rden), .mem_rdaddress(mem_rdaddress),
        .mem_rd_valid(mem_rd_valid), .mem_rddata(mem_rddata),
        .credits0(credits0), .credits1(credits1), .err_flags(err_flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] mkdata(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        for (int i = 0; i < DW; i++) d[i] = a[i % AW] ^ (((i / AW) % 2) == 1);
        return d;
    endfunction

    function automatic int cupd(input int c, input bit take, input bit give);
        if (take && !give) return c - 1;
        if (give && !take) return (c >= CR) ? CR : c + 1;
        return c;
    endfunction

    // Memory wrapper model: fixed latency, never reset.
    always @(posedge clk) begin
        mp_v[0] <= mem_rden;
        mp_a[0] <= mem_rdaddress;
        for (int i = 1; i < RL; i++) begin
            mp_v[i] <= mp_v[i-1];
            mp_a[i] <= mp_a[i-1];
        end
    end
    assign mem_rd_valid = (mp_v[RL-1] && !suppress) || inject;
    assign mem_rddata   = mkdata(mp_a[RL-1]);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic return_all();
        while (owed0 > 0 || owed1 > 0) begin
            crd0_return = (owed0 > 0);
            crd1_return = (owed1 > 0);
            if (owed0 > 0) owed0--;
            if (owed1 > 0) owed1--;
            tick();
        end
        crd0_return = 1'b0;
        crd1_return = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            sb_t e;
            bit  a0, a1;
            chk("mem_rden", mem_rden, prev_acc);
            if (prev_acc) chk("mem_rdaddress", mem_rdaddress, prev_addr);
            chk("rsp_exclusive", rsp0_valid && rsp1_valid, 0);
            if (rsp0_valid || rsp1_valid) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id", rsp1_valid, e.id);
                    chk("rsp_latency", cyc, e.cyc + RL + 2);
                    total++;
                    if ((rsp1_valid ? rsp1_data : rsp0_data) !== mkdata(e.addr)) begin
                        bad++;
                        $display("FAIL rsp_data: got %h want %h",
                                 rsp1_valid ? rsp1_data : rsp0_data, mkdata(e.addr));
                    end
                end
            end
            chk("credits0", credits0, exp_c0);
            chk("credits1", credits1, exp_c1);
            if (rst) begin
                sb.delete();
                exp_c0   = CR;
                exp_c1   = CR;
                owed0    = 0;
                owed1    = 0;
                prev_acc = 1'b0;
            end else begin
                if (suppress && mp_v[RL-1] && sb.size() > 0) void'(sb.pop_front());
                a0 = req0_valid && req0_ready;
                a1 = req1_valid && req1_ready;
                if (a0) begin sb.push_back('{1'b0, req0_addr, cyc}); owed0++; end
                if (a1) begin sb.push_back('{1'b1, req1_addr, cyc}); owed1++; end
                exp_c0    = cupd(exp_c0, a0, crd0_return);
                exp_c1    = cupd(exp_c1, a1, crd1_return);
                prev_acc  = a0 || a1;
                prev_addr = a1 ? req1_addr : req0_addr;
            end
        end
    end

    initial begin
        tbl[0] = '{0, 0, 12'h000, 12'h000, 0, 0};
        tbl[1] = '{1, 1, 12'h101, 12'h201, 0, 1};
        tbl[2] = '{1, 1, 12'h102, 12'h202, 1, 0};
        tbl[3] = '{1, 0, 12'h103, 12'h203, 1, 0};
        tbl[4] = '{1, 0, 12'h104, 12'h204, 1, 0};
        tbl[5] = '{1, 1, 12'h105, 12'h205, 0, 1};
        tbl[6] = '{0, 1, 12'h106, 12'h206, 0, 1};
        tbl[7] = '{1, 1, 12'h107, 12'h207, 1, 0};

        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; req0_addr = '0; req1_addr = '0;
        crd0_return = 0; crd1_return = 0;
        tick();
        mon_en = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_rden", mem_rden, 0);
        chk("rst_mem_rdaddress", mem_rdaddress, 0);
        chk("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
        chk("rst_rsp_data_zero", (rsp0_data == '0) && (rsp1_data == '0), 1);
        chk("rst_credits", {credits0, credits1}, {CW'(CR), CW'(CR)});
        chk("rst_err_flags", err_flags, 0);
        repeat (RL + 2) tick();

        // Single read on requester 0.
        req0_valid = 1; req0_addr = 12'h010;
        @(negedge clk);
        chk("single_ready0", req0_ready, 1);
        tick();
        req0_valid = 0;
        repeat (RL + 3) tick();
        @(negedge clk);
        chk("single_credit_used", credits0, CR - 1);
        tick();
        return_all();
        @(negedge clk);
        chk("single_credit_back", credits0, CR);
        tick();

        // Grant table; last grant is requester 0 after the single read.
        for (int i = 0; i < 8; i++) begin
            req0_valid = tbl[i].v0; req1_valid = tbl[i].v1;
            req0_addr  = tbl[i].a0; req1_addr  = tbl[i].a1;
            @(negedge clk);
            chk($sformatf("tbl%0d_ready0", i), req0_ready, tbl[i].r0);
            chk($sformatf("tbl%0d_ready1", i), req1_ready, tbl[i].r1);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            req0_valid = 1; req1_valid = 1;
            req0_addr = AW'(12'h400 + i); req1_addr = AW'(12'h500 + i);
            @(negedge clk);
            chk($sformatf("alt%0d_ready0", i), req0_ready, (i % 2) == 1);
            chk($sformatf("alt%0d_ready1", i), req1_ready, (i % 2) == 0);
            tick();
        end
        req0_valid = 0; req1_valid = 0;
        repeat (RL + 4) tick();
        return_all();

        // Credit exhaustion on requester 1.
        for (int i = 0; i < CR; i++) begin
            req1_valid = 1; req1_addr = AW'(12'h300 + i);
            @(negedge clk);
            chk($sformatf("exh%0d_ready1", i), req1_ready, 1);
            tick();
        end
        req0_valid = 1; req0_addr = 12'h0AA;
        @(negedge clk);
        chk("exh_ready1_blocked", req1_ready, 0);
        chk("exh_credits1_zero", credits1, 0);
        chk("exh_ready0_free", req0_ready, 1);
        tick();
        req0_valid = 0;
        crd1_return = 1; owed1--;
        @(negedge clk);
        chk("exh_ready1_during_return", req1_ready, 0);
        tick();
        crd1_return = 0;
        @(negedge clk);
        chk("exh_one_more", req1_ready, 1);
        tick();
        @(negedge clk);
        chk("exh_blocked_again", req1_ready, 0);
        tick();
        req1_valid = 0;
        repeat (RL + 4) tick();
        return_all();

        // Same-cycle accept and return, then return at full credits.
        req0_valid = 1; req0_addr = 12'h0C0; crd0_return = 1;
        @(negedge clk);
        chk("same_ready0", req0_ready, 1);
        tick();
        req0_valid = 0; crd0_return = 0; owed0--;
        @(negedge clk);
        chk("same_credits0", credits0, CR);
        chk("same_no_ovf", err_flags[2], 0);
        tick();
        crd0_return = 1;
        tick();
        crd0_return = 0;
        @(negedge clk);
        chk("ovf_credits0", credits0, CR);
        chk("ovf_err2", err_flags[2], 1);
        tick();
        repeat (RL + 4) tick();

        // Misalignment: unexpected return, then a missing one.
        inject = 1;
        tick();
        inject = 0;
        @(negedge clk);
        chk("unexp_err0", err_flags[0], 1);
        chk("unexp_err1_clear", err_flags[1], 0);
        tick();
        req0_valid = 1; req0_addr = 12'h055; suppress = 1;
        @(negedge clk);
        chk("miss_ready0", req0_ready, 1);
        tick();
        req0_valid = 0;
        repeat (RL + 3) tick();
        suppress = 0;
        @(negedge clk);
        chk("miss_err1", err_flags[1], 1);
        tick();
        return_all();

        // Reset mid-burst: memory still returns the five lines.
        for (int i = 0; i < 5; i++) begin
            req0_valid = 1; req0_addr = AW'(12'h600 + i);
            @(negedge clk);
            chk($sformatf("burst%0d_ready0", i), req0_ready, 1);
            tick();
        end
        req0_valid = 0;
        rst = 1;
        tick();
        rst = 0;
        repeat (RL + 6) tick();
        @(negedge clk);
        chk("rstmid_err_flags", err_flags, 0);
        chk("rstmid_credits0", credits0, CR);
        chk("rstmid_credits1", credits1, CR);
        tick();

        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
